// File: rtl/bcd_edit_field.sv
// bcd_edit_field: two-digit decimal edit field with edge-detected keys, load port and change strobe.
// Ports: clk; reset (async, active-low); KeyPlus/KeyMinus (active-low keys, async to clk);
//        EditMode, screen, EditPos (edit gating); LoadEn/LoadValue (direct load);
//        Value (registered field value); Changed (one-cycle pulse on every Value change).
// Optional hold-to-repeat is built when BCD_EDIT_AUTOREPEAT_EN is defined.
module bcd_edit_field #(
    parameter int WIDTH         = 7,
    parameter int MAX_VAL       = 59,
    parameter int SCREEN_ID     = 2,
    parameter int UNITS_POS     = 5,
    parameter int TENS_POS      = 4,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             KeyPlus,
    input  logic             KeyMinus,
    input  logic             EditMode,
    input  logic [1:0]       screen,
    input  logic [2:0]       EditPos,
    input  logic             LoadEn,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Value,
    output logic             Changed
);
    typedef enum logic [1:0] {IDLE, STEP, HOLD, REPEAT} state_t;
    localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] NINE = (WIDTH+1)'(9);
    localparam logic [WIDTH:0] TEN  = (WIDTH+1)'(10);
    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] TOPT = (WIDTH+1)'((MAX_VAL / 10) * 10);
    state_t           r_state, w_next;
    logic [1:0]       r_kp, r_km, r_rdy;
    logic             r_up, r_tens;
    logic             w_gate, w_press, w_key, w_step;
    logic [WIDTH:0]   w_v, w_u, w_c;
    logic [WIDTH-1:0] w_stepped, w_load, w_val;
    // Stage [0] is the key level; the press edge is taken between stages [1] and [0] so the
    // step lands on the third clock edge after the key falls.
    // r_rdy blocks edges until stage [1] holds a real sample, so a key held through reset never steps.
    assign w_gate  = EditMode && screen == 2'(SCREEN_ID) &&
                     (EditPos == 3'(UNITS_POS) || EditPos == 3'(TENS_POS));
    assign w_press = r_rdy[1] && w_gate &&
                     ((r_kp[1] && !r_kp[0] && r_km[0]) || (r_km[1] && !r_km[0] && r_kp[0]));
    assign w_key   = r_up ? r_kp[0] : r_km[0];
    assign w_v     = {1'b0, Value};
    assign w_u     = w_v % TEN;
    assign w_c     = TOPT + w_u;
    assign w_stepped = WIDTH'(r_tens
        ? (r_up ? ((w_v + TEN > MAXV) ? w_u : w_v + TEN)
                : ((w_v < TEN) ? ((w_c > MAXV) ? w_c - TEN : w_c) : w_v - TEN))
        : (r_up ? ((w_u == NINE || w_v == MAXV) ? w_v - w_u : w_v + ONE)
                : ((w_u == '0) ? ((w_v + NINE > MAXV) ? MAXV : w_v + NINE) : w_v - ONE)));
    assign w_load  = (LoadValue > WIDTH'(MAX_VAL)) ? WIDTH'(MAX_VAL) : LoadValue;
    assign w_val   = LoadEn ? w_load : w_step ? w_stepped : Value;
`ifdef BCD_EDIT_AUTOREPEAT_EN
    localparam int CW = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
    logic [CW-1:0] r_cnt;
    logic          w_quit;
    assign w_quit = !w_gate || w_key || !(r_up ? r_km[0] : r_kp[0]);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else        r_cnt <= (w_next != r_state || w_step) ? '0 : r_cnt + 1'b1;
    end
`endif
    always_comb begin
        w_next = r_state;
        w_step = 1'b0;
        case (r_state)
            IDLE: if (w_press) w_next = STEP;
            STEP: begin
                w_step = 1'b1;
                w_next = HOLD;
            end
`ifdef BCD_EDIT_AUTOREPEAT_EN
            HOLD:
                if (w_quit) w_next = IDLE;
                else if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                    w_next = REPEAT;
                    w_step = 1'b1;
                end
            REPEAT:
                if (w_quit) w_next = IDLE;
                else w_step = r_cnt == CW'(REPEAT_CYCLES - 1);
`else
            HOLD: if (!w_gate || w_key) w_next = IDLE;
`endif
            default: w_next = IDLE;
        endcase
        if (LoadEn) w_next = (!r_kp[0] || !r_km[0]) ? HOLD : IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_kp    <= 2'b11;
            r_km    <= 2'b11;
            r_rdy   <= 2'b00;
            r_up    <= 1'b0;
            r_tens  <= 1'b0;
            Value   <= '0;
            Changed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_kp    <= {r_kp[0], KeyPlus};
            r_km    <= {r_km[0], KeyMinus};
            r_rdy   <= {r_rdy[0], 1'b1};
            // Direction and digit follow the keys while idle and freeze once a press is taken.
            if (r_state == IDLE) begin
                r_up   <= !r_kp[0];
                r_tens <= EditPos == 3'(TENS_POS);
            end
            Value   <= w_val;
            Changed <= w_val != Value;
        end
    end
endmodule

// File: tb/tb_bcd_edit_field.sv
// tb_bcd_edit_field: scoreboard bench for two bcd_edit_field instances (MAX_VAL 59 and 23).
module tb_bcd_edit_field;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kp[2], km[2], ld[2], chg[2];
    logic [6:0] lv[2], val[2], prev[2];
    logic       em;
    logic [1:0] scr;
    logic [2:0] pos;
    int         cyc = 0, nchk = 0, nerr = 0;
    typedef struct {int inst; int v; int t;} exp_t;
    exp_t       sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_edit_field #(.WIDTH(7), .MAX_VAL(59), .SCREEN_ID(2), .UNITS_POS(5), .TENS_POS(4),
                     .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) u0 (
        .clk(clk), .reset(rst_n), .KeyPlus(kp[0]), .KeyMinus(km[0]), .EditMode(em),
        .screen(scr), .EditPos(pos), .LoadEn(ld[0]), .LoadValue(lv[0]),
        .Value(val[0]), .Changed(chg[0]));

    bcd_edit_field #(.WIDTH(7), .MAX_VAL(23), .SCREEN_ID(2), .UNITS_POS(5), .TENS_POS(4)) u1 (
        .clk(clk), .reset(rst_n), .KeyPlus(kp[1]), .KeyMinus(km[1]), .EditMode(em),
        .screen(scr), .EditPos(pos), .LoadEn(ld[1]), .LoadValue(lv[1]),
        .Value(val[1]), .Changed(chg[1]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk("changed_vs_value", chg[i], val[i] != prev[i]);
                if (chg[i]) begin
                    chk("sb_pending", sbq.size() != 0, 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("sb_inst", i, e.inst);
                        chk("sb_value", val[i], e.v);
                        chk("sb_cycle", cyc, e.t);
                    end
                end
                prev[i] = val[i];
            end
        end else begin
            prev[0] = '0;
            prev[1] = '0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int i, input bit up, input int hold, input bit step, input int ev);
        @(negedge clk);
        if (up) kp[i] = 1'b0; else km[i] = 1'b0;
        if (step) sbq.push_back('{i, ev, cyc + 3});
        tick(hold);
        kp[i] = 1'b1;
        km[i] = 1'b1;
        tick(4);
        chk("press_value", val[i], ev);
    endtask

    task automatic load(input int i, input int v, input int ev, input bit c);
        @(negedge clk);
        ld[i] = 1'b1;
        lv[i] = 7'(v);
        if (c) sbq.push_back('{i, ev, cyc + 1});
        @(negedge clk);
        ld[i] = 1'b0;
        chk("load_value", val[i], ev);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            kp[i] = 1'b1; km[i] = 1'b1; ld[i] = 1'b0; lv[i] = '0; prev[i] = '0;
        end
        em = 1'b1; scr = 2'd2; pos = 3'd5;
        tick(3);
        chk("reset_value0", val[0], 0);
        chk("reset_value1", val[1], 0);
        chk("reset_changed0", chg[0], 0);
        #2 rst_n = 1'b1;
        tick(4);
        // units increments wrap 9 -> 0
        for (int k = 1; k <= 10; k++) press(0, 1, 3, 1, k % 10);
        // tens digit, MAX 59
        pos = 3'd4;
        load(0, 52, 52, 1);
        press(0, 1, 3, 1, 2);
        press(0, 0, 3, 1, 52);
        load(0, 7, 7, 1);
        press(0, 0, 3, 1, 57);
        // MAX 23 instance
        load(1, 23, 23, 1);
        pos = 3'd5;
        press(1, 1, 3, 1, 20);
        press(1, 0, 3, 1, 23);
        load(1, 19, 19, 1);
        pos = 3'd4;
        press(1, 1, 3, 1, 9);
        load(1, 8, 8, 1);
        press(1, 0, 3, 1, 18);
        // no-step cases on instance 0 (Value 57)
        pos = 3'd5;
        @(negedge clk);
        kp[0] = 1'b0; km[0] = 1'b0;
        tick(5);
        kp[0] = 1'b1; km[0] = 1'b1;
        tick(4);
        chk("both_keys", val[0], 57);
        scr = 2'd1;
        press(0, 1, 3, 0, 57);
        scr = 2'd2; em = 1'b0;
        press(0, 1, 3, 0, 57);
        em = 1'b1; pos = 3'd3;
        press(0, 0, 3, 0, 57);
        pos = 3'd5;
        // second key pressed while first is held
        @(negedge clk);
        kp[0] = 1'b0;
        sbq.push_back('{0, 58, cyc + 3});
        tick(4);
        km[0] = 1'b0;
        tick(4);
        km[0] = 1'b1;
        tick(2);
        kp[0] = 1'b1;
        tick(4);
        chk("second_key", val[0], 58);
        // load in the STEP cycle wins and clamps
        @(negedge clk);
        kp[0] = 1'b0;
        n = cyc;
        tick(2);
        chk("step_cycle_align", cyc, n + 2);
        ld[0] = 1'b1; lv[0] = 7'd75;
        sbq.push_back('{0, 59, cyc + 1});
        @(negedge clk);
        ld[0] = 1'b0;
        tick(2);
        kp[0] = 1'b1;
        tick(4);
        chk("load_over_step", val[0], 59);
        load(0, 59, 59, 0);
        // reset while key held
        @(negedge clk);
        kp[0] = 1'b0;
        sbq.push_back('{0, 50, cyc + 3});
        tick(5);
        chk("sb_drained", sbq.size(), 0);
        #2 rst_n = 1'b0;
        tick(2);
        chk("midhold_reset0", val[0], 0);
        chk("midhold_reset1", val[1], 0);
        chk("midhold_changed", chg[0], 0);
        #2 rst_n = 1'b1;
        tick(10);
        chk("held_after_reset", val[0], 0);
        kp[0] = 1'b1;
        tick(4);
        // long hold from 0 on units
        @(negedge clk);
        kp[0] = 1'b0;
        n = cyc;
        sbq.push_back('{0, 1, n + 3});
`ifdef BCD_EDIT_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) sbq.push_back('{0, k + 2, n + 11 + 4 * k});
`endif
        tick(29);
        kp[0] = 1'b1;
        tick(8);
`ifdef BCD_EDIT_AUTOREPEAT_EN
        chk("long_hold", val[0], 6);
`else
        chk("long_hold", val[0], 1);
`endif
        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bcd_edit_field.md
Name: bcd_edit_field

Overview:
- Parametrised two-digit decimal edit field for the clock's settings screens. Generalises the time-zone-minutes manager to any range 0..MAX_VAL (minutes, hours, offsets), any screen and any digit positions.
- Adds edge-detected key presses, a load port, a change strobe and optional hold-to-repeat.
- Sits between the key debouncers / screen controller and the display mux; one instance per editable field.

Parameters:
- WIDTH, 7, width of Value; must hold MAX_VAL.
- MAX_VAL, 59, largest legal value (10..99).
- SCREEN_ID, 2, screen code on which this field is editable.
- UNITS_POS, 5, EditPos code selecting the units digit.
- TENS_POS, 4, EditPos code selecting the tens digit.
- HOLD_CYCLES, 25000000, cycles a key must stay held before auto-repeat starts (feature only).
- REPEAT_CYCLES, 5000000, cycles between repeated steps (feature only).

Ports:
- clk  in  1  main clock.
- reset  in  1  asynchronous, active-low reset.
- KeyPlus  in  1  active-low increment key, debounced, asynchronous to clk.
- KeyMinus  in  1  active-low decrement key, debounced, asynchronous to clk.
- EditMode  in  1  high = edit mode.
- screen  in  2  current screen code.
- EditPos  in  3  current edit position.
- LoadEn  in  1  high for one cycle: load LoadValue.
- LoadValue  in  WIDTH  value to load.
- Value  out  WIDTH  current field value, registered.
- Changed  out  1  one-cycle pulse whenever Value changes.

Behaviour:
- Reset (reset low, async): Value=0, Changed=0, FSM=IDLE, synchronisers=1 (released).
- KeyPlus/KeyMinus each pass through a 2-flop synchroniser; a press is a 1->0 transition on the synchronised signal.
- Gate = EditMode && screen==SCREEN_ID && (EditPos==UNITS_POS || EditPos==TENS_POS).
- Steps:
  - Units inc: if units==9 or Value==MAX_VAL then Value-units, else Value+1.
  - Units dec: if units==0 then min(Value+9, MAX_VAL), else Value-1.
  - Tens inc: if Value+10>MAX_VAL then Value%10, else Value+10.
  - Tens dec: if Value<10 then c=(MAX_VAL/10)*10+units, with c-10 used when c>MAX_VAL; else Value-10.
  - All arithmetic is on WIDTH+1 bits; Value never exceeds MAX_VAL.
- FSM states:
  - IDLE: on a press with Gate high and the other key released (synchronised high) -> STEP.
  - STEP: apply one step to Value, Changed=1 -> HOLD.
  - HOLD: wait for the key to release -> IDLE.
- Latency: Value updates on the 3rd rising clk edge after KeyX falls (2 sync + 1 STEP).
- Exactly one step per press; the direction and digit are latched at the press.
- Both keys pressed together, or the second key pressed while the first is held: no step.
- Gate low in HOLD -> IDLE immediately, no further steps. A key already held when Gate rises does not step (no edge).
- LoadEn: Value=min(LoadValue, MAX_VAL) next edge, Changed=1 only if the result differs from Value. LoadEn takes priority over a same-cycle STEP, which is discarded; FSM -> HOLD if a key is held, otherwise IDLE.
- Changed is registered and is 0 in every cycle without a Value change.
- Reset mid-hold: everything returns to reset values; a key still held after reset release does not step.

Optional Feature:
- Macro: BCD_EDIT_AUTOREPEAT_EN.
- Defined:
  - HOLD counts held cycles. After HOLD_CYCLES it moves to REPEAT.
  - REPEAT applies the latched step every REPEAT_CYCLES, with a Changed pulse on each step.
  - Release, Gate low, or the other key pressed -> IDLE.
  - Counters are sized with $clog2 of the larger of the two parameters and cleared on every state entry.
- Undefined: no counters are synthesised; HOLD only waits for release; HOLD_CYCLES and REPEAT_CYCLES are ignored.

Test Plan:
- Reset, then screen=2, EditMode=1, EditPos=5: press and release KeyPlus 10 times from Value=0 -> Value 1..9 then 0, Changed pulses 10 times, Value changes on the 3rd edge after each press.
- EditPos=4, Value=52, MAX_VAL=59: one KeyPlus -> 2; one KeyMinus -> 52; from Value=7, KeyMinus -> 57.
- Separate instance with MAX_VAL=23, Value=23:
  - units KeyPlus -> 20.
  - Value=20, units KeyMinus -> 23.
  - Value=19, tens KeyPlus -> 9.
  - Value=8, tens KeyMinus -> 18.
- Hold both keys, screen=1, or EditMode=0 while pressing -> no Value change, Changed stays 0.
- LoadEn with LoadValue=75 (MAX_VAL=59) in the STEP cycle -> Value=59, step discarded, one Changed pulse. Assert reset while a key is held -> Value=0; release reset with the key still held -> no step.
- With BCD_EDIT_AUTOREPEAT_EN, HOLD_CYCLES=8, REPEAT_CYCLES=4, units position: hold KeyPlus 30 cycles from Value=0 -> steps after press+3, +8 and every 4 cycles thereafter; stops on release.
